wb_stage_pipe: RTL and testbench
================================

// Module: wb_stage_pipe
// PURPOSE
// - Parametrised MEM->WB pipeline register. Carries LANES words of DATA_W bits plus the instruction PC.
// - Adds valid/ready elastic handshake, a 1-entry skid buffer, and a synchronous flush.
// - MEM stalls and hazard-unit flushes are absorbed here; no combinational path runs from out_ready to in_ready.
// PARAMETERS
// - DATA_W   32      width of each lane word
// - LANES    4       payload lanes (default: dmout, ao, pc, pcadd8)
// - PC_W     32      width of tag PC carried beside the payload
// PORTS
// - clk        in   1             clock, rising edge
// - reset      in   1             synchronous, active-high
// - flush      in   1             discard all held and incoming entries
// - in_valid   in   1             MEM-side entry present
// - in_ready   out  1             stage can accept (registered)
// - in_data    in   LANES*DATA_W  payload; lane k = bits [k*DATA_W +: DATA_W]
// - in_pc      in   PC_W          PC of incoming instruction
// - out_valid  out  1             WB-side entry present
// - out_ready  in   1             WB consumes entry
// - out_data   out  LANES*DATA_W  payload of head entry
// - out_pc     out  PC_W          PC of head entry
// - stall_cnt  out  32            only with WB_STAGE_PERF_EN
// - bubble_cnt out  32            only with WB_STAGE_PERF_EN
// BEHAVIOUR
// - Storage: main register (drives out_*) and skid register. Each has a valid bit.
// - Reset (sync): both valids=0, all data/pc=0, in_ready=1, out_valid=0, out_data=0, out_pc=0, counters=0.
// - Handshakes:
//   - Accept when in_valid && in_ready.
//   - Deliver when out_valid && out_ready.
//   - Latency is 1 cycle, in -> out, when main is empty or draining.
// - Per edge, with no flush:
//   - main empty or delivering: accepted entry -> main; otherwise if skid valid, skid -> main.
//   - main full and not delivering: accepted entry -> skid.
//   - skid valid and main delivering: skid -> main; a new accept is impossible, since in_ready=0.
// - in_ready is registered: next value = !(skid valid next cycle).
//   - Consequently in_ready=0 for exactly the cycles the skid holds an entry.
// - Order is strict FIFO. An entry never overtakes another; an entry is never duplicated or dropped, except by flush or reset.
// - Empty-and-valid edge: main empty and skid empty with an accept -> main only (skid unused).
// - Simultaneous deliver+accept with skid empty: new entry -> main; throughput 1/cycle.
// - flush (sync, one cycle):
//   - Next edge: both valids=0, main/skid data and pc=0, in_ready=1.
//   - flush has priority over any same-cycle accept; that input entry is dropped.
//   - A same-cycle deliver still completes as seen by WB.
// - reset has priority over flush. Reset mid-transfer discards everything.
// - When out_valid=0, out_data/out_pc hold the last value. They read 0 after reset or flush.
// - No arithmetic. Widths are fixed by parameters; no truncation.
// CONFIGURATION
// - WB_STAGE_PERF_EN defined:
//   - stall_cnt += 1 each cycle with out_valid && !out_ready.
//   - bubble_cnt += 1 each cycle with !out_valid and reset low.
//   - Both counters are 32-bit, wrap 0xFFFFFFFF -> 0, and are cleared only by reset (not by flush).
// - WB_STAGE_PERF_EN undefined: counter logic and both ports are absent. All other behaviour is identical.
// TESTING
// - Reset, then out_ready=1; push lanes {1,2,3,4}, pc=0x3000 -> out_valid=1 next cycle, out_data={1,2,3,4}, out_pc=0x3000.
// - Stream 8 entries (pc 0x3000..0x301C) with out_ready=1 -> 8 consecutive outputs, in order, in_ready stays 1.
// - Hold out_ready=0, push A(0x3000) then B(0x3004):
//   - B lands in skid; in_ready=0 next cycle; C is held off.
//   - Release out_ready -> output A, B, C in order, none lost.
// - Skid full, assert flush with in_valid=1 (D, pc=0x3010):
//   - Next cycle out_valid=0, in_ready=1, out_pc=0; D never appears.
// - Assert reset with an entry in main and in skid -> next cycle all outputs 0, in_ready=1; later traffic is unaffected.
// - WB_STAGE_PERF_EN:
//   - 5 cycles out_valid && !out_ready -> stall_cnt=5.
//   - Preload counter 0xFFFFFFFF, one more stall -> 0.
//   - A flush leaves both counters unchanged.

Source files
------------

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: MEM->WB pipeline register with a valid/ready handshake,
// a one-entry skid buffer and a synchronous flush.
// in_ready is registered, so out_ready never reaches in_ready combinationally.
// Optional feature macro: WB_STAGE_PERF_EN adds stall_cnt / bubble_cnt.
module wb_stage_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 4,
    parameter int unsigned PC_W   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]         in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [PC_W-1:0]         out_pc
`ifdef WB_STAGE_PERF_EN
    ,
    output logic [31:0]             stall_cnt,
    output logic [31:0]             bubble_cnt
`endif
);

    localparam int unsigned PAY_W = LANES * DATA_W;

    // Main register drives the outputs; the skid register catches the one
    // entry that may arrive while main is full and WB is stalled.
    logic             main_valid;
    logic [PAY_W-1:0] main_data;
    logic [PC_W-1:0]  main_pc;
    logic             skid_valid;
    logic [PAY_W-1:0] skid_data;
    logic [PC_W-1:0]  skid_pc;
    logic             ready_q;

    logic             main_valid_n;
    logic [PAY_W-1:0] main_data_n;
    logic [PC_W-1:0]  main_pc_n;
    logic             skid_valid_n;
    logic [PAY_W-1:0] skid_data_n;
    logic [PC_W-1:0]  skid_pc_n;

    logic accept;
    logic deliver;
    logic main_open;

    assign accept    = in_valid && ready_q;
    assign deliver   = main_valid && out_ready;
    assign main_open = !main_valid || deliver;

    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_pc    = main_pc;

    // Next-state selection for main and skid storage.
    // A valid skid always implies in_ready=0, so accept and skid->main never
    // compete; checking accept first keeps the empty-stage path to main only.
    always_comb begin
        main_valid_n = main_valid;
        main_data_n  = main_data;
        main_pc_n    = main_pc;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        skid_pc_n    = skid_pc;
        if (flush) begin
            main_valid_n = 1'b0;
            main_data_n  = '0;
            main_pc_n    = '0;
            skid_valid_n = 1'b0;
            skid_data_n  = '0;
            skid_pc_n    = '0;
        end else if (main_open) begin
            if (accept) begin
                main_valid_n = 1'b1;
                main_data_n  = in_data;
                main_pc_n    = in_pc;
            end else if (skid_valid) begin
                main_valid_n = 1'b1;
                main_data_n  = skid_data;
                main_pc_n    = skid_pc;
                skid_valid_n = 1'b0;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
            skid_pc_n    = in_pc;
        end
    end

    // Register storage; in_ready tracks the emptiness of the skid register.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_pc    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_pc    <= '0;
            ready_q    <= 1'b1;
        end else begin
            main_valid <= main_valid_n;
            main_data  <= main_data_n;
            main_pc    <= main_pc_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            skid_pc    <= skid_pc_n;
            ready_q    <= !skid_valid_n;
        end
    end

`ifdef WB_STAGE_PERF_EN
    // Performance counters: cleared only by reset, wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (main_valid && !out_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!main_valid) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

    // Structural invariants of the two-entry elastic buffer.
    a_skid_needs_main: assert property (@(posedge clk) disable iff (reset)
        skid_valid |-> main_valid);
    a_ready_vs_skid: assert property (@(posedge clk) disable iff (reset)
        in_ready == !skid_valid);

endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb_wb_stage_pipe: checks wb_stage_pipe against a queue-based model of a
// two-deep FIFO stage, with directed scenarios and a randomized phase.
module tb_wb_stage_pipe;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned PAY_W  = DATA_W * LANES;

    typedef logic [PAY_W-1:0] w_t;
    typedef struct packed {
        logic [PAY_W-1:0] d;
        logic [PC_W-1:0]  pc;
    } entry_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [PAY_W-1:0] in_data;
    logic [PC_W-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [PAY_W-1:0] out_data;
    logic [PC_W-1:0]  out_pc;
`ifdef WB_STAGE_PERF_EN
    logic [31:0]      stall_cnt;
    logic [31:0]      bubble_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_stage_pipe #(.DATA_W(DATA_W), .LANES(LANES), .PC_W(PC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pc    (out_pc)
`ifdef WB_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    // ---------------- reference model ----------------
    entry_t           mq[$];
    entry_t           shown = '0;
    bit               model_on = 1'b0;
    logic [31:0]      m_stall = '0;
    logic [31:0]      m_bubble = '0;
    logic [PC_W-1:0]  dlv[$];

    task automatic chk(input string name, input w_t got, input w_t exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Stage modelled as a FIFO of capacity two; outputs show the head,
    // holding the last head when empty, zero after reset/flush.
    always @(posedge clk) begin
        bit was_full;
        bit acc;
        if (reset) begin
            mq.delete();
            shown    = '0;
            m_stall  = '0;
            m_bubble = '0;
            model_on = 1'b1;
        end else if (model_on) begin
            was_full = (mq.size() > 0);
            if (was_full && !out_ready) m_stall = m_stall + 32'd1;
            if (!was_full) m_bubble = m_bubble + 32'd1;
            if (flush) begin
                mq.delete();
                shown = '0;
            end else begin
                acc = in_valid && (mq.size() < 2);
                if (was_full && out_ready) void'(mq.pop_front());
                if (acc) mq.push_back('{d: in_data, pc: in_pc});
                if (mq.size() > 0) shown = mq[0];
            end
        end
    end

    // Record what WB actually consumed.
    always @(posedge clk) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) dlv.push_back(out_pc);
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_on) begin
            chk("out_valid", w_t'(out_valid), w_t'(mq.size() > 0));
            chk("in_ready", w_t'(in_ready), w_t'(mq.size() < 2));
            chk("out_data", out_data, shown.d);
            chk("out_pc", w_t'(out_pc), w_t'(shown.pc));
`ifdef WB_STAGE_PERF_EN
            chk("stall_cnt", w_t'(stall_cnt), w_t'(m_stall));
            chk("bubble_cnt", w_t'(bubble_cnt), w_t'(m_bubble));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic w_t lanes4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Offer one entry and hold it until accepted (bounded).
    task automatic push(input w_t d, input logic [PC_W-1:0] pc);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_pc    = pc;
        for (int i = 0; i < 50; i++) begin
            ok = (in_ready === 1'b1);
            tick();
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_assert++;
            n_fail++;
            $display("FAIL push_timeout: pc %h not accepted, required acceptance within 50 cycles", pc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_pc     = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        chk("rst_out_valid", w_t'(out_valid), w_t'(0));
        chk("rst_in_ready", w_t'(in_ready), w_t'(1));
        chk("rst_out_data", out_data, w_t'(0));
        chk("rst_out_pc", w_t'(out_pc), w_t'(0));

        // Single entry, one-cycle latency.
        out_ready = 1'b1;
        push(lanes4(32'd1, 32'd2, 32'd3, 32'd4), 32'h3000);
        chk("lat_out_valid", w_t'(out_valid), w_t'(1));
        chk("lat_out_data", out_data, w_t'(128'h00000004_00000003_00000002_00000001));
        chk("lat_out_pc", w_t'(out_pc), w_t'(32'h3000));
        tick();

        // Back-to-back stream at full throughput.
        for (int i = 0; i < 8; i++) begin
            push(lanes4(i, i + 1, i + 2, i + 3), 32'h3000 + 32'(4 * i));
            chk("stream_pc", w_t'(out_pc), w_t'(32'h3000 + 32'(4 * i)));
            chk("stream_in_ready", w_t'(in_ready), w_t'(1));
        end
        tick();
        tick();

        // Stall: A in main, B in skid, C held off; release drains in order.
        out_ready = 1'b0;
        dlv.delete();
        push(lanes4(32'hA, 0, 0, 0), 32'h3000);
        push(lanes4(32'hB, 0, 0, 0), 32'h3004);
        chk("skid_in_ready", w_t'(in_ready), w_t'(0));
        in_valid = 1'b1;
        in_data  = lanes4(32'hC, 0, 0, 0);
        in_pc    = 32'h3008;
        tick();
        chk("held_out_pc", w_t'(out_pc), w_t'(32'h3000));
        chk("held_in_ready", w_t'(in_ready), w_t'(0));
        out_ready = 1'b1;
        push(lanes4(32'hC, 0, 0, 0), 32'h3008);
        tick();
        tick();
        chk("drain_count", w_t'(dlv.size()), w_t'(3));
        if (dlv.size() == 3) begin
            chk("drain_0", w_t'(dlv[0]), w_t'(32'h3000));
            chk("drain_1", w_t'(dlv[1]), w_t'(32'h3004));
            chk("drain_2", w_t'(dlv[2]), w_t'(32'h3008));
        end

        // Flush with skid full and a competing input D.
        out_ready = 1'b0;
        push(lanes4(32'hE, 0, 0, 0), 32'h3008);
        push(lanes4(32'hF, 0, 0, 0), 32'h300C);
        chk("pre_flush_in_ready", w_t'(in_ready), w_t'(0));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = lanes4(32'hD, 0, 0, 0);
        in_pc    = 32'h3010;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", w_t'(out_valid), w_t'(0));
        chk("flush_in_ready", w_t'(in_ready), w_t'(1));
        chk("flush_out_pc", w_t'(out_pc), w_t'(0));
        dlv.delete();
        out_ready = 1'b1;
        repeat (4) tick();
        chk("flush_no_delivery", w_t'(dlv.size()), w_t'(0));

        // Reset with both registers occupied.
        out_ready = 1'b0;
        push(lanes4(32'h6, 0, 0, 0), 32'h3020);
        push(lanes4(32'h7, 0, 0, 0), 32'h3024);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_out_valid", w_t'(out_valid), w_t'(0));
        chk("rst2_in_ready", w_t'(in_ready), w_t'(1));
        chk("rst2_out_data", out_data, w_t'(0));
        chk("rst2_out_pc", w_t'(out_pc), w_t'(0));
        out_ready = 1'b1;
        push(lanes4(32'h9, 0, 0, 0), 32'h3028);
        chk("post_rst_pc", w_t'(out_pc), w_t'(32'h3028));
        tick();

`ifdef WB_STAGE_PERF_EN
        // Counters: five stalls, wrap from all-ones, flush does not clear.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b0;
        push(lanes4(32'h11, 0, 0, 0), 32'h3030);
        repeat (5) tick();
        chk("stall_5", w_t'(stall_cnt), w_t'(5));
        force dut.stall_cnt = 32'hFFFF_FFFF;
        m_stall = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        tick();
        chk("stall_wrap", w_t'(stall_cnt), w_t'(0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_keeps_stall", w_t'(stall_cnt), w_t'(1));
        chk("flush_keeps_bubble", w_t'(bubble_cnt), w_t'(1));
`endif

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 2000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 23) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_pc     = $urandom;
            tick();
        end
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
